// File: rtl/rv16_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rv16_mem_arbiter
//
// Purpose:
//   Shares one memory port between the instruction-fetch requester and the
//   load/store requester of the RV16 core. Exactly one transaction is in
//   flight at a time. The bus command is registered at grant and held
//   constant until the memory answers with i_mem_ready, or until the wait
//   counter reaches TIMEOUT, in which case the transaction is aborted and the
//   owner receives an error pulse instead of an ack.
//
// Configuration:
//   RV16_ARB_RR_EN  when defined, contention between the two requesters is
//                   resolved round-robin through a 1-bit preference pointer.
//                   When undefined (default), data always beats fetch.
//
// Parameters:
//   TIMEOUT         BUSY cycles without i_mem_ready before abort (1..255).
//
// Ports:
//   clk, rst_n                    clock (rising edge), synchronous active-low reset
//   i_if_req, i_if_addr           fetch request and address
//   o_if_rdata, o_if_ack          fetch read data, completion pulse
//   o_if_err                      fetch timeout pulse
//   i_d_req, i_d_we, i_d_addr     data request, store flag, address
//   i_d_wdata, i_d_size           store data, access size code
//   o_d_rdata, o_d_ack, o_d_err   load data, completion pulse, timeout pulse
//   o_mem_addr, o_mem_wdata       shared memory address / write data
//   o_mem_read, o_mem_write       shared memory strobes (held for the access)
//   o_mem_size                    shared memory size code
//   i_mem_rdata, i_mem_ready      shared memory read data / completion
//   o_if_stall, o_d_stall         combinational stalls back to the core
// ----------------------------------------------------------------------------
module rv16_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    // Instruction fetch port
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ack,
    output logic        o_if_err,

    // Data (load/store) port
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [2:0]  i_d_size,
    output logic [31:0] o_d_rdata,
    output logic        o_d_ack,
    output logic        o_d_err,

    // Shared memory port
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [2:0]  o_mem_size,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready,

    // Stalls
    output logic        o_if_stall,
    output logic        o_d_stall
);

    // Fetches are always full-word reads.
    localparam logic [2:0] FETCH_SIZE  = 3'b010;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait;

`ifdef RV16_ARB_RR_EN
    // 1 = data is preferred on the next contention, 0 = fetch is preferred.
    logic        r_rr_pref_d;
`endif

    logic [7:0]  w_wait_inc;
    logic        w_timeout;
    logic        w_if_cand;
    logic        w_d_cand;
    logic        w_grant_d;
    logic        w_grant_if;

    // A requester whose ack/err is pulsing this cycle is still holding req
    // from the transaction that just finished; that req is stale and must
    // not start a second transaction. The other requester may be granted.
    assign w_if_cand = i_if_req & ~(o_if_ack | o_if_err);
    assign w_d_cand  = i_d_req  & ~(o_d_ack  | o_d_err);

`ifdef RV16_ARB_RR_EN
    assign w_grant_d = w_d_cand & (~w_if_cand | r_rr_pref_d);
`else
    assign w_grant_d = w_d_cand;
`endif
    assign w_grant_if = w_if_cand & ~w_grant_d;

    // The counter value this BUSY cycle would end with if memory stays silent.
    assign w_wait_inc = r_wait + 8'd1;
    assign w_timeout  = (w_wait_inc == TIMEOUT_CNT);

    assign o_if_stall = i_if_req & ~o_if_ack;
    assign o_d_stall  = i_d_req  & ~o_d_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wait      <= 8'd0;
            o_if_rdata  <= 32'd0;
            o_if_ack    <= 1'b0;
            o_if_err    <= 1'b0;
            o_d_rdata   <= 32'd0;
            o_d_ack     <= 1'b0;
            o_d_err     <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 32'd0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_size  <= 3'd0;
`ifdef RV16_ARB_RR_EN
            r_rr_pref_d <= 1'b1;
`endif
        end else begin
            // Completion and error indications are single-cycle pulses.
            o_if_ack <= 1'b0;
            o_if_err <= 1'b0;
            o_d_ack  <= 1'b0;
            o_d_err  <= 1'b0;

            case (r_state)
                IDLE: begin
                    // i_mem_ready is deliberately not looked at here.
                    if (w_grant_d) begin
                        r_state     <= D_BUSY;
                        r_wait      <= 8'd0;
                        o_mem_addr  <= i_d_addr;
                        o_mem_wdata <= i_d_wdata;
                        o_mem_size  <= i_d_size;
                        o_mem_read  <= ~i_d_we;
                        o_mem_write <= i_d_we;
`ifdef RV16_ARB_RR_EN
                        r_rr_pref_d <= 1'b0;
`endif
                    end else if (w_grant_if) begin
                        r_state     <= IF_BUSY;
                        r_wait      <= 8'd0;
                        o_mem_addr  <= i_if_addr;
                        o_mem_wdata <= 32'd0;
                        o_mem_size  <= FETCH_SIZE;
                        o_mem_read  <= 1'b1;
                        o_mem_write <= 1'b0;
`ifdef RV16_ARB_RR_EN
                        r_rr_pref_d <= 1'b1;
`endif
                    end
                end

                IF_BUSY, D_BUSY: begin
                    // The bus command registers are not touched here, so the
                    // command stays stable whatever the requesters do.
                    if (i_mem_ready) begin
                        // Ready is checked first so that it beats a timeout
                        // landing on the same edge. Stores capture too; the
                        // value is simply unused by the core.
                        if (r_state == D_BUSY) begin
                            o_d_ack   <= 1'b1;
                            o_d_rdata <= i_mem_rdata;
                        end else begin
                            o_if_ack   <= 1'b1;
                            o_if_rdata <= i_mem_rdata;
                        end
                        o_mem_read  <= 1'b0;
                        o_mem_write <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_timeout) begin
                        // Abort: error pulse to the owner, read data untouched.
                        if (r_state == D_BUSY) begin
                            o_d_err <= 1'b1;
                        end else begin
                            o_if_err <= 1'b1;
                        end
                        o_mem_read  <= 1'b0;
                        o_mem_write <= 1'b0;
                        r_wait      <= w_wait_inc;
                        r_state     <= IDLE;
                    end else begin
                        r_wait <= w_wait_inc;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    o_mem_read  <= 1'b0;
                    o_mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
